// File: rtl/disp_pkg.sv
// Shared display constants for the seven-segment path.
// Contents:
//   bcd_seg_t - 7-bit active-low segment vector, bit 0 = a .. bit 6 = g
//   SEG_OFF   - all segments dark
//   SEG_DASH  - segment g only, used for non-decimal codes 10..15
//   SEG_LUT   - 16-entry code-to-segment table
package disp_pkg;

  typedef logic [6:0] bcd_seg_t;

  localparam bcd_seg_t SEG_OFF  = 7'h7F;
  localparam bcd_seg_t SEG_DASH = 7'h3F;

  localparam bcd_seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder (active-low outputs).
// Ports:
//   code_i  in  4  digit code; 10..15 decode to a dash
//   seg_o   out 7  segments a..g on bits 0..6, active-low
module bcd_to_7seg
  import disp_pkg::*;
(
  input  logic     [3:0] code_i,
  output bcd_seg_t       seg_o
);

  assign seg_o = SEG_LUT[code_i];

endmodule

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed seven-segment scanner. Captures a packed BCD vector into a
// shadow register, transfers it to the display register only at a frame
// boundary (tear-free), and scans one digit per slot with a blanked lead-in
// at the start of each slot to suppress ghosting.
// Optional feature: define BCD_7SEG_LZB_EN for leading-zero blanking.
// Ports:
//   clk_i        in  1         system clock
//   rst_n_i      in  1         asynchronous active-low reset
//   bcd_i        in  DIGITS*4  packed BCD, digit 0 in [3:0]
//   bcd_valid_i  in  1         capture strobe for bcd_i
//   frame_o      out 1         pulse aligned with the first output cycle of digit 0
//   seg_o        out 7         segments a..g, active-low
//   an_o         out DIGITS    anode enables, active-low
module bcd_7seg_scan
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DIGITS*4-1:0]   bcd_i,
  input  logic                  bcd_valid_i,
  output logic                  frame_o,
  output logic [6:0]            seg_o,
  output logic [DIGITS-1:0]     an_o
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CntW-1:0]     r_cnt;
  logic [IdxW-1:0]     r_idx;
  logic [DIGITS*4-1:0] r_shadow;
  logic [DIGITS*4-1:0] r_disp;
  logic                r_pend;
  logic                r_wrap;
  logic                r_frame;
  bcd_seg_t            r_seg;
  logic [DIGITS-1:0]   r_an;

  logic                w_tick;
  logic                w_wrap;
  logic                w_blank_slot;
  logic                w_hide;
  logic [3:0]          w_digit;
  bcd_seg_t            w_dec;
  bcd_seg_t            w_seg_nxt;
  logic [DIGITS-1:0]   w_an_nxt;

  assign w_tick       = (r_cnt == CntW'(SCAN_DIV - 1));
  assign w_wrap       = w_tick && (r_idx == IdxW'(DIGITS - 1));
  assign w_blank_slot = (32'(r_cnt) < BLANK_CYC);

  // Select the display digit for the current slot.
  always_comb begin
    w_digit = 4'h0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IdxW'(i)) w_digit = r_disp[4*i +: 4];
    end
  end

`ifdef BCD_7SEG_LZB_EN
  // w_lead[i] is set when display digits i..DIGITS-1 are all zero; digit 0
  // is never hidden so a zero value still shows "0".
  logic [DIGITS-1:0] w_lead;
  logic              w_upper_zero;

  always_comb begin
    w_lead       = '0;
    w_upper_zero = 1'b1;
    w_hide       = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      w_upper_zero = w_upper_zero && (r_disp[4*i +: 4] == 4'h0);
      w_lead[i]    = w_upper_zero;
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IdxW'(i)) w_hide = w_lead[i];
    end
  end
`else
  assign w_hide = 1'b0;
`endif

  bcd_to_7seg u_dec (
    .code_i (w_digit),
    .seg_o  (w_dec)
  );

  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SEG_OFF;
    if (!w_blank_slot && !w_hide) begin
      w_seg_nxt = w_dec;
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (r_idx == IdxW'(i)) w_an_nxt[i] = 1'b0;
      end
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IdxW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadow / display transfer. A strobe coinciding with the boundary copy
  // wins the pending flag, so the new value is shown one frame later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shadow <= '0;
      r_disp   <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (w_wrap && r_pend) begin
        r_disp <= r_shadow;
      end
      if (bcd_valid_i) begin
        r_shadow <= bcd_i;
        r_pend   <= 1'b1;
      end else if (w_wrap) begin
        r_pend   <= 1'b0;
      end
    end
  end

  // Output registers. frame_o goes through two stages so it lines up with
  // the registered output of digit 0's first slot cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wrap  <= 1'b0;
      r_frame <= 1'b0;
      r_seg   <= SEG_OFF;
      r_an    <= '1;
    end else begin
      r_wrap  <= w_wrap;
      r_frame <= r_wrap;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
    end
  end

  assign frame_o = r_frame;
  assign seg_o   = r_seg;
  assign an_o    = r_an;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
module tb_bcd_7seg_scan;

  localparam int unsigned D = 3;
  localparam int unsigned S = 4;
  localparam int unsigned B = 1;
  localparam int unsigned F = D * S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [11:0] bcd = '0;
  logic        frame;
  logic [6:0]  seg;
  logic [2:0]  an;

  always #5 clk = ~clk;

  bcd_7seg_scan #(
    .DIGITS    (D),
    .SCAN_DIV  (S),
    .BLANK_CYC (B)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bcd_i       (bcd),
    .bcd_valid_i (valid),
    .frame_o     (frame),
    .seg_o       (seg),
    .an_o        (an)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: absolute cycle position since reset release plus the
  // architectural shadow/display/pending state.
  int unsigned m_p;
  logic [11:0] m_shadow;
  logic [11:0] m_disp;
  bit          m_pend;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic bit hidden(input int idx);
`ifdef BCD_7SEG_LZB_EN
    // Digit idx is a leading zero when the whole value is below 16**idx.
    return (idx > 0) && (int'(m_disp) < (1 << (4 * idx)));
`else
    return (idx < 0);
`endif
  endfunction

  task automatic model_reset();
    m_p = 0;
    m_shadow = '0;
    m_disp = '0;
    m_pend = 1'b0;
  endtask

  task automatic step(input bit v, input logic [11:0] d);
    int cnt;
    int idx;
    logic [6:0] e_seg;
    logic [2:0] e_an;
    bit e_frame;
    valid = v;
    bcd = d;
    cnt = int'(m_p % S);
    idx = int'((m_p / S) % D);
    e_frame = (m_p > 0) && (m_p % F == 0);
    if (cnt < int'(B) || hidden(idx)) begin
      e_seg = 7'h7F;
      e_an = 3'b111;
    end else begin
      e_seg = seg_of(int'((m_disp >> (4 * idx)) & 12'hF));
      e_an = 3'b111 & ~(3'b001 << idx);
    end
    @(posedge clk);
    #1;
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("frame", 32'(frame), 32'(e_frame));
    if ((m_p % F == F - 1) && m_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (v) begin
      m_shadow = d;
      m_pend = 1'b1;
    end
    m_p++;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000);
  endtask

  task automatic run_to(input int unsigned ph);
    while (m_p % F != ph) step(1'b0, 12'h000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
    check_eq({tag, "_an"}, 32'(an), 32'h7);
    check_eq({tag, "_frame"}, 32'(frame), 32'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    idle(24);

    // Capture mid-frame; current frame keeps showing 000.
    run_to(5);
    step(1'b1, 12'h123);
    run_to(0);
    idle(12);

    // Two strobes in one frame: the later one wins.
    run_to(2);
    step(1'b1, 12'h456);
    step(1'b0, 12'h000);
    step(1'b1, 12'h789);
    run_to(0);
    idle(12);

    // Strobe on the wrap tick while another value is pending.
    run_to(5);
    step(1'b1, 12'h111);
    run_to(F - 1);
    step(1'b1, 12'h222);
    idle(24);

    // Non-decimal code, then leading-zero cases.
    step(1'b1, 12'hA05);
    idle(24);
    step(1'b1, 12'h007);
    idle(24);
    step(1'b1, 12'h000);
    idle(24);

    // Reset mid-frame with data pending: pending value is lost.
    step(1'b1, 12'h350);
    idle(14);
    run_to(6);
    step(1'b1, 12'h999);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(24);

    // Randomized strobes and codes.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), 12'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
